// File: rtl/mmio_pkg.sv
// Purpose: shared constants and types for the MMIO "virtual memory" bank that
// sits beside DMEM. Holds the window offsets, the status-word overflow bit
// position, the decoded-access types and a small address helper.
// Ports: none (package).
package mmio_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CODE_W = 8;

  // Offsets inside the keyboard window.
  localparam int KBD_DATA_OFS = 0;
  localparam int KBD_STAT_OFS = 1;

  // Offsets inside one player's slot, and the distance between slots.
  localparam int PX_OFS        = 0;
  localparam int PY_OFS        = 1;
  localparam int PVEL_OFS      = 2;
  localparam int PLAYER_STRIDE = 4;

  // Sticky-overflow flag position in the keyboard status word.
  localparam int OVF_BIT = 31;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_KBD_DATA,
    ACC_KBD_STAT,
    ACC_PLAYER
  } acc_kind_e;

  // Encodings match the PX/PY/PVEL offsets so a slot offset casts straight in.
  typedef enum logic [1:0] {
    FLD_X    = 2'd0,
    FLD_Y    = 2'd1,
    FLD_VEL  = 2'd2,
    FLD_NONE = 2'd3
  } player_fld_e;

  typedef struct packed {
    acc_kind_e          kind;
    logic [ADDR_W-3:0]  player;
    player_fld_e        field;
  } mmio_dec_t;

  // The processor data address is only 12 bits wide, so the decimal bases
  // (4100, 4200, ...) are seen modulo 4096 on the bus.
  function automatic logic [ADDR_W-1:0] bus_addr(input int base);
    return base[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Purpose: scan-code FIFO for the keyboard window. Power-of-two depth, pointers
// wrap naturally, occupancy count is one bit wider than the pointers.
// A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only when
// a pop happens in the same cycle (the caller decides what to do with drops).
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wdata this cycle
//   pop    in   advance the head this cycle
//   wdata  in   WIDTH  code to store
//   head   out  WIDTH  oldest stored code (undefined when empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  $clog2(DEPTH)+1  current occupancy
module kbd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage has no reset: the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_virtual_mem.sv
// Purpose: memory-mapped I/O bank above DMEM for the game processor. Decodes
// processor data-port accesses in the keyboard and player windows, buffers
// PS/2 scan codes in a FIFO, holds per-player x/y/velocity registers and
// returns registered read data (one cycle latency) for the proc_data_in mux.
// Ports:
//   clock            in   system clock, all state on posedge
//   reset            in   asynchronous active-low reset
//   address_dmem     in   12   processor data address
//   wren             in   processor write enable
//   data             in   32   processor write data
//   ps2_key_pressed  in   PS/2 code-valid level (rising edge pushes)
//   ps2_out          in   8    PS/2 scan code
//   mmio_hit         out  previous-cycle address was a mapped location
//   mmio_rdata       out  32   registered read data
//   isKeyboardLoad   out  one-cycle pulse after a keyboard data read
//   player_x         out  32*NUM_PLAYERS  player i x at [32*i +: 32]
//   player_y         out  32*NUM_PLAYERS  player i y at [32*i +: 32]
module mmio_virtual_mem
  import mmio_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int KBD_DEPTH   = 8,
  parameter int KBD_BASE    = 4100,
  parameter int PLAYER_BASE = 4200,
  parameter int RESET_X     = 240,
  parameter int RESET_Y     = 240
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address_dmem,
  input  logic                        wren,
  input  logic [DATA_W-1:0]           data,
  input  logic                        ps2_key_pressed,
  input  logic [CODE_W-1:0]           ps2_out,
  output logic                        mmio_hit,
  output logic [DATA_W-1:0]           mmio_rdata,
  output logic                        isKeyboardLoad,
  output logic [32*NUM_PLAYERS-1:0]   player_x,
  output logic [32*NUM_PLAYERS-1:0]   player_y
);

  localparam int CNT_W = $clog2(KBD_DEPTH) + 1;

  localparam logic [ADDR_W-1:0] KBD_DATA_ADDR = bus_addr(KBD_BASE + KBD_DATA_OFS);
  localparam logic [ADDR_W-1:0] KBD_STAT_ADDR = bus_addr(KBD_BASE + KBD_STAT_OFS);
  localparam logic [ADDR_W-1:0] PLAYER_ADDR   = bus_addr(PLAYER_BASE);

  mmio_dec_t          dec;
  logic [ADDR_W-1:0]  player_off;
  logic               key_q;
  logic               push;
  logic               pop_req;
  logic               stat_rd;
  logic               wr_player;
  logic               drop;
  logic               overflow;
  logic [DATA_W-1:0]  rdata_next;

  logic [CODE_W-1:0]  fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  logic [DATA_W-1:0]  px [NUM_PLAYERS];
  logic [DATA_W-1:0]  py [NUM_PLAYERS];
  logic [DATA_W-1:0]  pvel [NUM_PLAYERS];

  // Address decode. A player slot is PLAYER_STRIDE (4) words, so the slot
  // index is the offset above bit 1 and the field is the low two bits; the
  // fourth word of each slot is a hole.
  always_comb begin
    dec        = '{kind: ACC_NONE, player: '0, field: FLD_NONE};
    player_off = address_dmem - PLAYER_ADDR;
    if (address_dmem == KBD_DATA_ADDR) begin
      dec.kind = ACC_KBD_DATA;
    end else if (address_dmem == KBD_STAT_ADDR) begin
      dec.kind = ACC_KBD_STAT;
    end else if ((address_dmem >= PLAYER_ADDR) &&
                 (player_off[ADDR_W-1:2] < (ADDR_W-2)'(NUM_PLAYERS)) &&
                 (player_off[1:0] != 2'(PLAYER_STRIDE - 1))) begin
      dec.kind   = ACC_PLAYER;
      dec.player = player_off[ADDR_W-1:2];
      dec.field  = player_fld_e'(player_off[1:0]);
    end
  end

  assign push      = ps2_key_pressed && !key_q;
  assign pop_req   = (dec.kind == ACC_KBD_DATA) && !wren;
  assign stat_rd   = (dec.kind == ACC_KBD_STAT) && !wren;
  assign wr_player = (dec.kind == ACC_PLAYER) && wren;
  // A code is lost only when the FIFO is full and nothing leaves this cycle.
  assign drop      = push && fifo_full && !pop_req;

  kbd_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop_req),
    .wdata (ps2_out),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Edge-detect history and sticky overflow. A drop in the same cycle as a
  // status read wins, so the flag stays set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      key_q <= ps2_key_pressed;
      if (drop) begin
        overflow <= 1'b1;
      end else if (stat_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  // Player register array.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        px[i]   <= DATA_W'(RESET_X);
        py[i]   <= DATA_W'(RESET_Y);
        pvel[i] <= '0;
      end
    end else if (wr_player) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (dec.player == (ADDR_W-2)'(i)) begin
          case (dec.field)
            FLD_X:   px[i]   <= data;
            FLD_Y:   py[i]   <= data;
            FLD_VEL: pvel[i] <= data;
            default: ;
          endcase
        end
      end
    end
  end

  // Read mux. Writes and unmapped reads return zero; an empty FIFO read
  // returns zero rather than a stale head.
  always_comb begin
    rdata_next = '0;
    if (!wren) begin
      case (dec.kind)
        ACC_KBD_DATA: begin
          if (!fifo_empty) begin
            rdata_next = {{(DATA_W-CODE_W){1'b0}}, fifo_head};
          end
        end
        ACC_KBD_STAT: begin
          rdata_next[OVF_BIT] = overflow;
          rdata_next[7:0]     = 8'(fifo_count);
        end
        ACC_PLAYER: begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (dec.player == (ADDR_W-2)'(i)) begin
              case (dec.field)
                FLD_X:   rdata_next = px[i];
                FLD_Y:   rdata_next = py[i];
                FLD_VEL: rdata_next = pvel[i];
                default: rdata_next = '0;
              endcase
            end
          end
        end
        default: rdata_next = '0;
      endcase
    end
  end

  // Registered read port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mmio_hit       <= 1'b0;
      mmio_rdata     <= '0;
      isKeyboardLoad <= 1'b0;
    end else begin
      mmio_hit       <= (dec.kind != ACC_NONE);
      mmio_rdata     <= rdata_next;
      isKeyboardLoad <= pop_req;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player_out
    assign player_x[32*g +: 32] = px[g];
    assign player_y[32*g +: 32] = py[g];
  end

endmodule
